// File: rtl/aes_pkg.sv
// Shared AES constants, phase encodings and GF(2^8) helpers for the
// inverse round datapath.
package aes_pkg;

  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned WORD_W  = 32;
  localparam int unsigned BLOCK_W = 128;
  localparam int unsigned ROUND_W = 4;
  localparam int unsigned ACC_W   = 3 * WORD_W;

  // Round-10 key of the cipher key 000102..0f, byte 0 in bits [7:0].
  localparam logic [BLOCK_W-1:0] K10_INIT_DFLT = 128'hc5302b4d8ba707f3174a94e37f1d1113;

  typedef enum logic [2:0] {
    PH_IDLE = 3'd0,
    PH_COL0 = 3'd1,
    PH_COL1 = 3'd2,
    PH_COL2 = 3'd3,
    PH_COL3 = 3'd4
  } phase_e;

  function automatic logic [BYTE_W-1:0] rcon(input logic [ROUND_W-1:0] r);
    logic [BYTE_W-1:0] rc;
    case (r)
      4'd0:    rc = 8'h01;
      4'd1:    rc = 8'h02;
      4'd2:    rc = 8'h04;
      4'd3:    rc = 8'h08;
      4'd4:    rc = 8'h10;
      4'd5:    rc = 8'h20;
      4'd6:    rc = 8'h40;
      4'd7:    rc = 8'h80;
      4'd8:    rc = 8'h1b;
      4'd9:    rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

  function automatic logic [BYTE_W-1:0] xtime(input logic [BYTE_W-1:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [BYTE_W-1:0] x2(input logic [BYTE_W-1:0] a);
    return xtime(a);
  endfunction

  function automatic logic [BYTE_W-1:0] x9(input logic [BYTE_W-1:0] a);
    return x2(x2(x2(a))) ^ a;
  endfunction

  function automatic logic [BYTE_W-1:0] x11(input logic [BYTE_W-1:0] a);
    return x2(x2(x2(a))) ^ x2(a) ^ a;
  endfunction

  function automatic logic [BYTE_W-1:0] x13(input logic [BYTE_W-1:0] a);
    return x2(x2(x2(a))) ^ x2(x2(a)) ^ a;
  endfunction

  function automatic logic [BYTE_W-1:0] x14(input logic [BYTE_W-1:0] a);
    return x2(x2(x2(a))) ^ x2(x2(a)) ^ x2(a);
  endfunction

  function automatic logic [BYTE_W-1:0] gmul(input logic [BYTE_W-1:0] a,
                                             input logic [BYTE_W-1:0] b);
    logic [BYTE_W-1:0] p;
    logic [BYTE_W-1:0] t;
    p = '0;
    t = a;
    for (int i = 0; i < int'(BYTE_W); i++) begin
      if (b[i]) p = p ^ t;
      t = xtime(t);
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse (and maps 0 to 0).
  function automatic logic [BYTE_W-1:0] gf_inv(input logic [BYTE_W-1:0] a);
    logic [BYTE_W-1:0] p;
    logic [BYTE_W-1:0] r;
    p = a;
    r = 8'h01;
    for (int k = 1; k < 8; k++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r;
  endfunction

  function automatic logic [BYTE_W-1:0] rotl8(input logic [BYTE_W-1:0] x,
                                              input int unsigned n);
    return (x << n) | (x >> (BYTE_W - n));
  endfunction

  function automatic logic [BYTE_W-1:0] sbox_fwd(input logic [BYTE_W-1:0] x);
    logic [BYTE_W-1:0] b;
    b = gf_inv(x);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [BYTE_W-1:0] sbox_inv(input logic [BYTE_W-1:0] s);
    return gf_inv(rotl8(s, 1) ^ rotl8(s, 3) ^ rotl8(s, 6) ^ 8'h05);
  endfunction

endpackage

// File: rtl/aes_inv_column.sv
// One column of an inverse round: InvSubBytes, AddRoundKey and
// InvMixColumns (bypassed for the final round). Purely combinational.
module aes_inv_column
  import aes_pkg::*;
(
  input  logic [WORD_W-1:0] col_i,
  input  logic [WORD_W-1:0] rkey_i,
  input  logic              bypass_i,
  output logic [WORD_W-1:0] col_o
);

  logic [BYTE_W-1:0] a [4];
  logic [BYTE_W-1:0] m [4];

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      a[i] = sbox_inv(col_i[BYTE_W*i +: BYTE_W]) ^ rkey_i[BYTE_W*i +: BYTE_W];
    end
    // Circulant {0e,0b,0d,09}: row i weights a[i], a[i+1], a[i+2], a[i+3].
    for (int i = 0; i < 4; i++) begin
      m[i] = x14(a[2'(i)]) ^ x11(a[2'(i + 1)]) ^ x13(a[2'(i + 2)]) ^ x9(a[2'(i + 3)]);
    end
    col_o = '0;
    for (int i = 0; i < 4; i++) begin
      col_o[BYTE_W*i +: BYTE_W] = bypass_i ? a[i] : m[i];
    end
  end

endmodule

// File: rtl/tbox0.sv
// Forward S-box byte of the T0 table; used by SubWord in the inverse key
// expansion.
module tbox0
  import aes_pkg::*;
(
  input  logic [BYTE_W-1:0] idx_i,
  output logic [BYTE_W-1:0] sbox_o
);

  assign sbox_o = sbox_fwd(idx_i);

endmodule

// File: rtl/aes_inv_round.sv
// AES-128 decryption round engine: derives K_r from K_{r+1} on start, then
// processes one state column per cycle through a shared column unit.
module aes_inv_round
  import aes_pkg::*;
#(
  parameter logic [BLOCK_W-1:0] K10_INIT = K10_INIT_DFLT
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               enable,
  input  logic [BLOCK_W-1:0] i_text,
  input  logic [BLOCK_W-1:0] key,
  input  logic [ROUND_W-1:0] round,
  output logic [BLOCK_W-1:0] o_text,
  output logic [BLOCK_W-1:0] Rkey,
  output logic               done
);

  phase_e             phase_q, phase_d;
  logic [BLOCK_W-1:0] text_q, text_d;
  logic [ROUND_W-1:0] round_q, round_d;
  logic [BLOCK_W-1:0] kr_q, kr_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [BLOCK_W-1:0] o_text_q, o_text_d;
  logic [BLOCK_W-1:0] rkey_q, rkey_d;

  // Inverse key expansion on the live inputs: K_{r+1} -> K_r.
  logic [WORD_W-1:0]  w0_p, w1_p, w2_p, w3_p, rot_w, sub_w;
  logic [BLOCK_W-1:0] kr_next;

  assign w3_p  = key[127:96] ^ key[95:64];
  assign w2_p  = key[95:64] ^ key[63:32];
  assign w1_p  = key[63:32] ^ key[31:0];
  assign rot_w = {w3_p[7:0], w3_p[31:8]};

  for (genvar b = 0; b < 4; b++) begin : g_subword
    tbox0 u_tbox0 (
      .idx_i  (rot_w[BYTE_W*b +: BYTE_W]),
      .sbox_o (sub_w[BYTE_W*b +: BYTE_W])
    );
  end

  assign w0_p    = key[31:0] ^ sub_w ^ WORD_W'(rcon(round));
  assign kr_next = {w3_p, w2_p, w1_p, w0_p};

  // InvShiftRows column gather and round-key column select for this phase.
  logic [1:0]        col_sel;
  logic [1:0]        src;
  logic [WORD_W-1:0] shr_col, rk_col, col_res;

  always_comb begin
    col_sel = 2'(phase_q - PH_COL0);
    src     = '0;
    shr_col = '0;
    for (int i = 0; i < 4; i++) begin
      src = col_sel - 2'(i);
      shr_col[BYTE_W*i +: BYTE_W] = text_q[WORD_W*src + BYTE_W*i +: BYTE_W];
    end
    rk_col = kr_q[WORD_W*col_sel +: WORD_W];
  end

  aes_inv_column u_col (
    .col_i    (shr_col),
    .rkey_i   (rk_col),
    .bypass_i (round_q == ROUND_W'(0)),
    .col_o    (col_res)
  );

  always_ff @(posedge clock) begin
    if (!resetn) begin
      phase_q  <= PH_IDLE;
      text_q   <= '0;
      round_q  <= '0;
      kr_q     <= '0;
      acc_q    <= '0;
      o_text_q <= '0;
      rkey_q   <= K10_INIT;
    end else begin
      phase_q  <= phase_d;
      text_q   <= text_d;
      round_q  <= round_d;
      kr_q     <= kr_d;
      acc_q    <= acc_d;
      o_text_q <= o_text_d;
      rkey_q   <= rkey_d;
    end
  end

  always_comb begin
    phase_d  = phase_q;
    text_d   = text_q;
    round_d  = round_q;
    kr_d     = kr_q;
    acc_d    = acc_q;
    o_text_d = o_text_q;
    rkey_d   = rkey_q;
    case (phase_q)
      PH_IDLE: begin
        if (enable) begin
          text_d  = i_text;
          round_d = round;
          kr_d    = kr_next;
          phase_d = PH_COL0;
        end
      end
      PH_COL0: begin
        acc_d[31:0] = col_res;
        phase_d     = PH_COL1;
      end
      PH_COL1: begin
        acc_d[63:32] = col_res;
        phase_d      = PH_COL2;
      end
      PH_COL2: begin
        acc_d[95:64] = col_res;
        phase_d      = PH_COL3;
      end
      PH_COL3: begin
        o_text_d = {col_res, acc_q};
        rkey_d   = (round_q == ROUND_W'(0)) ? K10_INIT : kr_q;
        phase_d  = PH_IDLE;
      end
      default: phase_d = PH_IDLE;
    endcase
  end

  assign o_text = o_text_q;
  assign Rkey   = rkey_q;
  assign done   = (phase_q == PH_COL3);

endmodule

// File: tb/tb_aes_inv_round.sv
// Scoreboard bench for aes_inv_round: table-driven AES reference model,
// directed FIPS-197 vectors plus randomized rounds.
module tb_aes_inv_round;

  localparam logic [127:0] K10    = 128'hc5302b4d8ba707f3174a94e37f1d1113;
  localparam logic [127:0] R9_IN  = 128'h7ad5fda789ef4e272bca100b3d9ff59f;
  localparam logic [127:0] R9_KEY = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] R9_OUT = 128'h54d990a16ba09ab596bbf40ea111702f;
  localparam logic [127:0] R9_RK  = 128'h549932d1f08557681093ed9cbe2c974e;
  localparam logic [127:0] R0_IN  = 128'h6353e08c0960e104cd70b751bacad0e7;
  localparam logic [127:0] R0_KEY = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
  localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT     = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CKEY   = 128'h000102030405060708090a0b0c0d0e0f;

  logic         clock;
  logic         resetn;
  logic         enable;
  logic [127:0] i_text;
  logic [127:0] key;
  logic [3:0]   round;
  logic [127:0] o_text;
  logic [127:0] Rkey;
  logic         done;

  aes_inv_round dut (
    .clock  (clock),
    .resetn (resetn),
    .enable (enable),
    .i_text (i_text),
    .key    (key),
    .round  (round),
    .o_text (o_text),
    .Rkey   (Rkey),
    .done   (done)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  logic [31:0] cyc;
  initial begin
    cyc = 0;
    forever begin
      @(posedge clock);
      cyc = cyc + 1;
    end
  end

  int n_vec = 0;
  int n_err = 0;
  int n_done = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp_v);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0]   sb  [256];
  logic [7:0]   isb [256];
  logic [127:0] ks  [11];

  // Carry-less product then polynomial reduction by 0x11b.
  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 15; i >= 8; i--) if (p[i]) p = p ^ (16'h011b << (i - 8));
    return p[7:0];
  endfunction

  task automatic build_tables();
    logic [7:0] c;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      logic [7:0] b;
      logic [7:0] s;
      b = 8'h00;
      for (int y = 1; y < 256; y++) if (gm(8'(x), 8'(y)) == 8'h01) b = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = b[i] ^ b[(i + 4) % 8] ^ b[(i + 5) % 8] ^ b[(i + 6) % 8] ^ b[(i + 7) % 8] ^ c[i];
      sb[x]  = s;
      isb[s] = 8'(x);
    end
  endtask

  task automatic expand_key(input logic [127:0] ck);
    logic [7:0] w [44][4];
    logic [7:0] t [4];
    logic [7:0] rc;
    logic [7:0] tmp;
    rc = 8'h01;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) w[i][j] = ck[8*(4*i+j) +: 8];
    for (int i = 4; i < 44; i++) begin
      for (int j = 0; j < 4; j++) t[j] = w[i-1][j];
      if (i % 4 == 0) begin
        tmp  = t[0];
        t[0] = sb[t[1]] ^ rc;
        t[1] = sb[t[2]];
        t[2] = sb[t[3]];
        t[3] = sb[tmp];
        rc   = gm(rc, 8'h02);
      end
      for (int j = 0; j < 4; j++) w[i][j] = w[i-4][j] ^ t[j];
    end
    for (int r = 0; r < 11; r++)
      for (int c2 = 0; c2 < 4; c2++)
        for (int j = 0; j < 4; j++) ks[r][8*(4*c2+j) +: 8] = w[4*r+c2][j];
  endtask

  function automatic logic [127:0] inv_round(input logic [127:0] s, input logic [127:0] k,
                                             input int r);
    logic [7:0]   st [4][4];
    logic [7:0]   a  [4][4];
    logic [7:0]   coef [4];
    logic [7:0]   acc;
    logic [127:0] o;
    coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    for (int row = 0; row < 4; row++)
      for (int col = 0; col < 4; col++) st[row][col] = s[8*(4*col+row) +: 8];
    for (int row = 0; row < 4; row++)
      for (int col = 0; col < 4; col++)
        a[row][col] = isb[st[row][(col - row + 4) % 4]] ^ k[8*(4*col+row) +: 8];
    o = '0;
    for (int col = 0; col < 4; col++)
      for (int row = 0; row < 4; row++) begin
        if (r == 0) acc = a[row][col];
        else begin
          acc = 8'h00;
          for (int j = 0; j < 4; j++) acc = acc ^ gm(coef[(j - row + 4) % 4], a[j][col]);
        end
        o[8*(4*col+row) +: 8] = acc;
      end
    return o;
  endfunction

  function automatic logic [127:0] brev(input logic [127:0] x);
    logic [127:0] y;
    for (int n = 0; n < 16; n++) y[8*n +: 8] = x[8*(15-n) +: 8];
    return y;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [127:0] txt;
    logic [127:0] rk;
    logic [31:0]  dcyc;
  } exp_t;

  exp_t sb_q [$];
  exp_t cur_item;
  bit   chk_pending = 1'b0;

  task automatic push_exp(input logic [127:0] t, input logic [127:0] r, input logic [31:0] d);
    exp_t e;
    e.txt  = t;
    e.rk   = r;
    e.dcyc = d;
    sb_q.push_back(e);
  endtask

  initial begin
    forever begin
      @(negedge clock);
      if (chk_pending) begin
        chk_pending = 1'b0;
        chk("o_text", o_text, cur_item.txt);
        chk("Rkey", Rkey, cur_item.rk);
      end
      if (done === 1'b1) begin
        n_done++;
        if (sb_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_done: got done=1 at cycle %0d expected none", cyc);
        end else begin
          cur_item = sb_q.pop_front();
          chk("done_cycle", 128'(cyc), 128'(cur_item.dcyc));
          chk_pending = 1'b1;
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic start_round(input logic [127:0] t, input logic [127:0] k, input logic [3:0] r,
                             input logic [127:0] et, input logic [127:0] ek);
    i_text = t;
    key    = k;
    round  = r;
    enable = 1'b1;
    push_exp(et, ek, cyc + 32'd4);
    @(negedge clock);
    enable = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sb_q.size() != 0 || chk_pending) && n < 60) begin
      @(negedge clock);
      n++;
    end
    if (n >= 60) begin
      n_vec++;
      n_err++;
      $display("FAIL timeout: got %0d results outstanding expected 0", sb_q.size());
      sb_q.delete();
      chk_pending = 1'b0;
    end
  endtask

  initial begin
    logic [127:0] cur_txt, cur_key, m_txt;
    logic [31:0]  k0;
    int           done0;
    int           r;

    resetn = 1'b0;
    enable = 1'b1;
    i_text = rnd128();
    key    = rnd128();
    round  = 4'd9;
    build_tables();

    // Reset with enable held high.
    repeat (2) @(negedge clock);
    chk("rst_o_text", o_text, 128'h0);
    chk("rst_Rkey", Rkey, K10);
    chk("rst_done", 128'(done), 128'h0);
    resetn = 1'b1;
    enable = 1'b0;
    @(negedge clock);
    chk("idle_done", 128'(done), 128'h0);

    // Directed FIPS-197 rounds.
    start_round(brev(R9_IN), brev(R9_KEY), 4'd9, brev(R9_OUT), brev(R9_RK));
    wait_idle();
    start_round(brev(R0_IN), brev(R0_KEY), 4'd0, brev(PT), K10);
    wait_idle();

    // Randomized rounds against the model.
    for (int it = 0; it < 30; it++) begin
      expand_key(rnd128());
      r       = int'($urandom_range(0, 9));
      cur_txt = rnd128();
      start_round(cur_txt, ks[r+1], 4'(r), inv_round(cur_txt, ks[r], r),
                  (r == 0) ? K10 : ks[r]);
      wait_idle();
      repeat ($urandom_range(0, 2)) @(negedge clock);
    end

    // Inputs change during phases 1..4; enable stays high into the next round.
    i_text = brev(R9_IN);
    key    = brev(R9_KEY);
    round  = 4'd9;
    enable = 1'b1;
    push_exp(brev(R9_OUT), brev(R9_RK), cyc + 32'd4);
    repeat (4) begin
      @(negedge clock);
      i_text = rnd128();
      key    = rnd128();
      round  = 4'($urandom_range(0, 15));
    end
    @(negedge clock);
    i_text = brev(R0_IN);
    key    = brev(R0_KEY);
    round  = 4'd0;
    push_exp(brev(PT), K10, cyc + 32'd4);
    @(negedge clock);
    enable = 1'b0;
    wait_idle();

    // Reset in phase 2 discards the round.
    i_text = brev(R9_IN);
    key    = brev(R9_KEY);
    round  = 4'd9;
    enable = 1'b1;
    push_exp(brev(R9_OUT), brev(R9_RK), cyc + 32'd4);
    @(negedge clock);
    enable = 1'b0;
    @(negedge clock);
    resetn = 1'b0;
    sb_q.delete();
    @(negedge clock);
    chk("midrst_o_text", o_text, 128'h0);
    chk("midrst_Rkey", Rkey, K10);
    chk("midrst_done", 128'(done), 128'h0);
    resetn = 1'b1;
    repeat (6) @(negedge clock);
    start_round(brev(R9_IN), brev(R9_KEY), 4'd9, brev(R9_OUT), brev(R9_RK));
    wait_idle();

    // Full decrypt: rounds 9..0 chained back to back.
    expand_key(brev(CKEY));
    cur_key = K10;
    cur_txt = brev(CT) ^ K10;
    m_txt   = cur_txt;
    done0   = n_done;
    k0      = cyc;
    for (int rr = 9; rr >= 0; rr--) begin
      m_txt = inv_round(m_txt, ks[rr], rr);
      push_exp(m_txt, (rr == 0) ? K10 : ks[rr], cyc + 32'd4);
      i_text = cur_txt;
      key    = cur_key;
      round  = 4'(rr);
      enable = 1'b1;
      repeat (5) @(negedge clock);
      cur_txt = o_text;
      cur_key = Rkey;
    end
    enable = 1'b0;
    chk("decrypt_pt", cur_txt, brev(PT));
    chk("decrypt_done_pulses", 128'(n_done - done0), 128'd10);
    chk("decrypt_cycles", 128'(cyc - k0), 128'd50);
    wait_idle();
    repeat (3) @(negedge clock);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
